grf_wb_scheduler: RTL and testbench

- Schedules the single write port of the general register file (GRF) between two writeback sources:
  - the in-order pipeline WB stage;
  - the long-latency unit (MDU / multi-cycle load), which has a valid/ready handshake.
- Keeps a 32-entry busy scoreboard of registers with outstanding long-latency writes, so issue logic can stall on RAW hazards.
- Sits directly in front of the GRF write/debug ports. Grant is combinational, so the GRF and the scoreboard update on the same clk edge.

---
 rtl/cpu_pkg.sv | 17 +
 rtl/grf_scoreboard.sv | 71 +++++++
 rtl/grf_wb_scheduler.sv | 161 ++++++++++++++++
 tb/tb_grf_wb_scheduler.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared widths and scheduler state encoding for the GRF writeback slice.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpu_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;
  localparam int NUM_REGS   = 32;

  // ARB: normal priority arbitration, pipeline first.
  // FORCE: single cycle that hands the write port to a starved MDU result.
  typedef enum logic {
    ARB   = 1'b0,
    FORCE = 1'b1
  } sched_state_t;

endpackage

// File: rtl/grf_scoreboard.sv
// Busy scoreboard for registers with outstanding long-latency writes.
// Latency: busy bits update at the clk edge; queries see same-cycle issues combinationally.
// Backpressure: none; sb_err flags an issue to an already-busy register (sticky).
module grf_scoreboard
  import cpu_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  issue_valid,
  input  logic [REG_ADDR_W-1:0] issue_waddr,
  input  logic                  clr_valid,
  input  logic [REG_ADDR_W-1:0] clr_waddr,
  input  logic [REG_ADDR_W-1:0] rs_addr,
  input  logic [REG_ADDR_W-1:0] rt_addr,
  output logic                  rs_busy,
  output logic                  rt_busy,
  output logic                  sb_err
);

  // Register 0 is never tracked, so only bits 31..1 are stored.
  logic [NUM_REGS-1:1] r_busy;
  logic                r_err;

  logic [NUM_REGS-1:0] w_busy_full;
  logic [NUM_REGS-1:1] w_set;
  logic [NUM_REGS-1:1] w_clr;
  logic [NUM_REGS-1:1] w_busy_nxt;
  logic                w_issue_conflict;
  logic                w_rs_issue;
  logic                w_rt_issue;

  assign w_busy_full = {r_busy, 1'b0};

  // Decode set/clear masks; set is applied after clear so a re-issue keeps the bit.
  always_comb begin
    w_set      = '0;
    w_clr      = '0;
    w_busy_nxt = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      w_set[i]      = issue_valid && (issue_waddr == REG_ADDR_W'(i));
      w_clr[i]      = clr_valid && (clr_waddr == REG_ADDR_W'(i));
      w_busy_nxt[i] = (r_busy[i] && !w_clr[i]) || w_set[i];
    end
  end

  // Conflict is judged on the bit as it stood before this cycle's clear.
  assign w_issue_conflict = issue_valid && w_busy_full[issue_waddr];

  // Same-cycle issue is visible to the query ports; same-cycle clear is not,
  // because the consumer reads the GRF only after the write edge.
  assign w_rs_issue = issue_valid && (issue_waddr == rs_addr) && (rs_addr != '0);
  assign w_rt_issue = issue_valid && (issue_waddr == rt_addr) && (rt_addr != '0);

  assign rs_busy = w_busy_full[rs_addr] || w_rs_issue;
  assign rt_busy = w_busy_full[rt_addr] || w_rt_issue;
  assign sb_err  = r_err;

  // Busy bits and sticky error flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_busy <= '0;
      r_err  <= 1'b0;
    end else begin
      r_busy <= w_busy_nxt;
      if (w_issue_conflict) begin
        r_err <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/grf_wb_scheduler.sv
// Arbitrates the single GRF write port between the pipeline WB stage and the MDU.
// Latency: 0 cycles, grant and grf_* are combinational; state/counter/scoreboard update at the edge.
// Backpressure: pipe_stall holds WB in a forced MDU cycle; mdu_ready low holds the MDU result.
module grf_wb_scheduler
  import cpu_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  // 2**CNT_W must exceed STARVE_LIMIT so the counter can reach the limit.
  parameter int CNT_W        = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  pipe_wen,
  input  logic [REG_ADDR_W-1:0] pipe_waddr,
  input  logic [DATA_W-1:0]     pipe_wdata,
  input  logic [DATA_W-1:0]     pipe_pc,
  output logic                  pipe_stall,
  input  logic                  mdu_valid,
  input  logic [REG_ADDR_W-1:0] mdu_waddr,
  input  logic [DATA_W-1:0]     mdu_wdata,
  input  logic [DATA_W-1:0]     mdu_pc,
  output logic                  mdu_ready,
  input  logic                  issue_valid,
  input  logic [REG_ADDR_W-1:0] issue_waddr,
  input  logic [REG_ADDR_W-1:0] rs_addr,
  input  logic [REG_ADDR_W-1:0] rt_addr,
  output logic                  rs_busy,
  output logic                  rt_busy,
  output logic [REG_ADDR_W-1:0] grf_waddr,
  output logic [DATA_W-1:0]     grf_wdata,
  output logic [DATA_W-1:0]     grf_pc,
  output logic                  sb_err
);

  sched_state_t r_state;
  sched_state_t w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;

  logic                  w_pipe_req;
  logic                  w_mdu_req;
  logic                  w_pipe_stall;
  logic                  w_mdu_ready;
  logic [REG_ADDR_W-1:0] w_grf_waddr;
  logic [DATA_W-1:0]     w_grf_wdata;
  logic [DATA_W-1:0]     w_grf_pc;
  logic                  w_mdu_accept;

  // A pipeline write to r0 is not a request; an MDU result always is,
  // even to r0, so it gets drained from the MDU.
  assign w_pipe_req = pipe_wen && (pipe_waddr != '0);
  assign w_mdu_req  = mdu_valid;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ARB;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state: a forced MDU cycle follows the edge at which starvation hits the limit.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ARB: begin
        if (w_cnt_nxt == CNT_W'(STARVE_LIMIT)) begin
          w_state_nxt = FORCE;
        end
      end
      FORCE: begin
        w_state_nxt = ARB;
      end
      default: begin
        w_state_nxt = ARB;
      end
    endcase
  end

  // Outputs: grant decision and write-port mux; everything is quiet while in reset.
  always_comb begin
    w_pipe_stall = 1'b0;
    w_mdu_ready  = 1'b0;
    w_grf_waddr  = '0;
    w_grf_wdata  = '0;
    w_grf_pc     = pipe_pc;
    if (!reset) begin
      case (r_state)
        ARB: begin
          if (w_pipe_req) begin
            w_grf_waddr = pipe_waddr;
            w_grf_wdata = pipe_wdata;
            w_grf_pc    = pipe_pc;
          end else if (w_mdu_req) begin
            w_mdu_ready = 1'b1;
            w_grf_waddr = mdu_waddr;
            w_grf_wdata = mdu_wdata;
            w_grf_pc    = mdu_pc;
          end
        end
        FORCE: begin
          // The forced cycle is taken even if the MDU withdrew its result;
          // in that case the port idles (waddr 0).
          w_pipe_stall = 1'b1;
          w_mdu_ready  = 1'b1;
          if (w_mdu_req) begin
            w_grf_waddr = mdu_waddr;
            w_grf_wdata = mdu_wdata;
            w_grf_pc    = mdu_pc;
          end
        end
        default: begin
          w_pipe_stall = 1'b0;
        end
      endcase
    end
  end

  // Starvation count: any MDU acceptance resets it, each lost ARB cycle bumps it.
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (w_mdu_ready) begin
      w_cnt_nxt = '0;
    end else if ((r_state == ARB) && w_mdu_req) begin
      w_cnt_nxt = r_cnt + CNT_W'(1);
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_nxt;
    end
  end

  assign w_mdu_accept = w_mdu_ready && mdu_valid;

  grf_scoreboard u_scoreboard (
    .clk         (clk),
    .reset       (reset),
    .issue_valid (issue_valid),
    .issue_waddr (issue_waddr),
    .clr_valid   (w_mdu_accept),
    .clr_waddr   (mdu_waddr),
    .rs_addr     (rs_addr),
    .rt_addr     (rt_addr),
    .rs_busy     (rs_busy),
    .rt_busy     (rt_busy),
    .sb_err      (sb_err)
  );

  assign pipe_stall = w_pipe_stall;
  assign mdu_ready  = w_mdu_ready;
  assign grf_waddr  = w_grf_waddr;
  assign grf_wdata  = w_grf_wdata;
  assign grf_pc     = w_grf_pc;

endmodule

// File: tb/tb_grf_wb_scheduler.sv
// Directed bench for grf_wb_scheduler with a queue-based scoreboard.
// Stimulus pushes expected output values per cycle; a negedge monitor pops and compares.
// Inputs change 1ns after posedge; outputs are sampled on the following negedge.
module tb_grf_wb_scheduler;

  localparam int K_WADDR = 0;
  localparam int K_WDATA = 1;
  localparam int K_PC    = 2;
  localparam int K_STALL = 3;
  localparam int K_READY = 4;
  localparam int K_RSB   = 5;
  localparam int K_RTB   = 6;
  localparam int K_ERR   = 7;

  typedef struct {
    string       name;
    int          kind;
    logic [31:0] val;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        pipe_wen;
  logic [4:0]  pipe_waddr;
  logic [31:0] pipe_wdata;
  logic [31:0] pipe_pc;
  logic        pipe_stall;
  logic        mdu_valid;
  logic [4:0]  mdu_waddr;
  logic [31:0] mdu_wdata;
  logic [31:0] mdu_pc;
  logic        mdu_ready;
  logic        issue_valid;
  logic [4:0]  issue_waddr;
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
  logic        rs_busy;
  logic        rt_busy;
  logic [4:0]  grf_waddr;
  logic [31:0] grf_wdata;
  logic [31:0] grf_pc;
  logic        sb_err;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  grf_wb_scheduler #(.STARVE_LIMIT(4), .CNT_W(3)) dut (
    .clk         (clk),
    .reset       (reset),
    .pipe_wen    (pipe_wen),
    .pipe_waddr  (pipe_waddr),
    .pipe_wdata  (pipe_wdata),
    .pipe_pc     (pipe_pc),
    .pipe_stall  (pipe_stall),
    .mdu_valid   (mdu_valid),
    .mdu_waddr   (mdu_waddr),
    .mdu_wdata   (mdu_wdata),
    .mdu_pc      (mdu_pc),
    .mdu_ready   (mdu_ready),
    .issue_valid (issue_valid),
    .issue_waddr (issue_waddr),
    .rs_addr     (rs_addr),
    .rt_addr     (rt_addr),
    .rs_busy     (rs_busy),
    .rt_busy     (rt_busy),
    .grf_waddr   (grf_waddr),
    .grf_wdata   (grf_wdata),
    .grf_pc      (grf_pc),
    .sb_err      (sb_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] actual(input int k);
    case (k)
      K_WADDR: return {27'd0, grf_waddr};
      K_WDATA: return grf_wdata;
      K_PC:    return grf_pc;
      K_STALL: return {31'd0, pipe_stall};
      K_READY: return {31'd0, mdu_ready};
      K_RSB:   return {31'd0, rs_busy};
      K_RTB:   return {31'd0, rt_busy};
      default: return {31'd0, sb_err};
    endcase
  endfunction

  // Monitor: every negedge, compare all expectations queued for this cycle.
  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      exp_t e;
      logic [31:0] a;
      e = exp_q.pop_front();
      a = actual(e.kind);
      n_checks++;
      if (a !== e.val) begin
        n_errors++;
        $display("FAIL %s: got %h expected %h", e.name, a, e.val);
      end
    end
  end

  task automatic ex(input string n, input int k, input logic [31:0] v);
    exp_t e;
    e.name = n;
    e.kind = k;
    e.val  = v;
    exp_q.push_back(e);
  endtask

  task automatic grf(input string n, input logic [31:0] a, input logic [31:0] d, input logic [31:0] p);
    ex({n, "_waddr"}, K_WADDR, a);
    ex({n, "_wdata"}, K_WDATA, d);
    ex({n, "_pc"},    K_PC,    p);
  endtask

  task automatic hs(input string n, input logic stall, input logic ready);
    ex({n, "_stall"}, K_STALL, {31'd0, stall});
    ex({n, "_ready"}, K_READY, {31'd0, ready});
  endtask

  task automatic idle_in();
    pipe_wen    = 1'b0;
    pipe_waddr  = '0;
    pipe_wdata  = '0;
    pipe_pc     = '0;
    mdu_valid   = 1'b0;
    mdu_waddr   = '0;
    mdu_wdata   = '0;
    mdu_pc      = '0;
    issue_valid = 1'b0;
    issue_waddr = '0;
    rs_addr     = '0;
    rt_addr     = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic both_req(input logic [4:0] ma, input logic [31:0] ppc);
    idle_in();
    pipe_wen   = 1'b1;
    pipe_waddr = 5'd5;
    pipe_wdata = 32'h1111_0000 ^ ppc;
    pipe_pc    = ppc;
    mdu_valid  = 1'b1;
    mdu_waddr  = ma;
    mdu_wdata  = 32'h0000_AAAA;
    mdu_pc     = 32'h0000_0400;
  endtask

  initial begin
    // Reset cycle: requests present but everything must stay quiet.
    idle_in();
    reset      = 1'b1;
    pipe_wen   = 1'b1;
    pipe_waddr = 5'd5;
    mdu_valid  = 1'b1;
    mdu_waddr  = 5'd9;
    rs_addr    = 5'd9;
    ex("rst_waddr", K_WADDR, 32'd0);
    hs("rst", 1'b0, 1'b0);
    ex("rst_err", K_ERR, 32'd0);
    ex("rst_rsb", K_RSB, 32'd0);
    step();
    reset = 1'b0;
    idle_in();
    step();

    // Pipeline only.
    pipe_wen = 1'b1; pipe_waddr = 5'd5; pipe_wdata = 32'hDEAD_BEEF; pipe_pc = 32'h100;
    grf("pipe", 32'd5, 32'hDEAD_BEEF, 32'h100);
    hs("pipe", 1'b0, 1'b0);
    step();
    idle_in(); pipe_pc = 32'h104;
    grf("idle", 32'd0, 32'd0, 32'h104);
    hs("idle", 1'b0, 1'b0);
    step();
    idle_in(); pipe_wen = 1'b1; pipe_waddr = 5'd0; pipe_wdata = 32'h55; pipe_pc = 32'h108;
    grf("pipe_r0", 32'd0, 32'd0, 32'h108);
    step();

    // MDU only: issue r8, observe busy, accept, observe clear.
    idle_in(); issue_valid = 1'b1; issue_waddr = 5'd8; rs_addr = 5'd8;
    ex("iss8_rsb", K_RSB, 32'd1);
    ex("iss8_err", K_ERR, 32'd0);
    step();
    idle_in(); rs_addr = 5'd8; rt_addr = 5'd9;
    ex("busy8_rsb", K_RSB, 32'd1);
    ex("busy9_rtb", K_RTB, 32'd0);
    step();
    idle_in(); mdu_valid = 1'b1; mdu_waddr = 5'd8; mdu_wdata = 32'h1234; mdu_pc = 32'h200; rs_addr = 5'd8;
    grf("mdu8", 32'd8, 32'h1234, 32'h200);
    hs("mdu8", 1'b0, 1'b1);
    ex("mdu8_rsb", K_RSB, 32'd1);
    step();
    idle_in(); rs_addr = 5'd8;
    ex("clr8_rsb", K_RSB, 32'd0);
    step();

    // Starvation: four pipeline wins, then a forced MDU cycle, then pipeline again.
    for (int i = 0; i < 4; i++) begin
      both_req(5'd12, 32'h300 + 32'(4 * i));
      grf("starve", 32'd5, 32'h1111_0000 ^ (32'h300 + 32'(4 * i)), 32'h300 + 32'(4 * i));
      hs("starve", 1'b0, 1'b0);
      step();
    end
    both_req(5'd12, 32'h310);
    grf("force", 32'd12, 32'h0000_AAAA, 32'h400);
    hs("force", 1'b1, 1'b1);
    step();
    both_req(5'd12, 32'h314);
    mdu_valid = 1'b0;
    grf("after_force", 32'd5, 32'h1111_0314, 32'h314);
    hs("after_force", 1'b0, 1'b0);
    step();

    // Set and clear of r3 in the same cycle: set wins, no error.
    idle_in(); mdu_valid = 1'b1; mdu_waddr = 5'd3; mdu_wdata = 32'h33; mdu_pc = 32'h500;
    issue_valid = 1'b1; issue_waddr = 5'd3; rs_addr = 5'd3;
    hs("sc3", 1'b0, 1'b1);
    ex("sc3_rsb", K_RSB, 32'd1);
    step();
    idle_in(); rs_addr = 5'd3;
    ex("sc3_after_rsb", K_RSB, 32'd1);
    ex("sc3_err", K_ERR, 32'd0);
    step();
    idle_in(); mdu_valid = 1'b1; mdu_waddr = 5'd3; mdu_wdata = 32'h3333; mdu_pc = 32'h504;
    grf("clr3", 32'd3, 32'h3333, 32'h504);
    step();
    idle_in(); rs_addr = 5'd3;
    ex("clr3_rsb", K_RSB, 32'd0);
    step();

    // Double issue to r10 without a clear: sticky error.
    idle_in(); issue_valid = 1'b1; issue_waddr = 5'd10;
    ex("dbl1_err", K_ERR, 32'd0);
    step();
    idle_in(); issue_valid = 1'b1; issue_waddr = 5'd10; rs_addr = 5'd10;
    ex("dbl2_err", K_ERR, 32'd0);
    ex("dbl2_rsb", K_RSB, 32'd1);
    step();
    idle_in(); rt_addr = 5'd10;
    ex("dbl_err_set", K_ERR, 32'd1);
    ex("dbl_rtb", K_RTB, 32'd1);
    step();
    idle_in();
    ex("dbl_err_hold", K_ERR, 32'd1);
    step();

    // Drive into FORCE again, then reset during the forced cycle.
    for (int i = 0; i < 4; i++) begin
      both_req(5'd13, 32'h600 + 32'(4 * i));
      hs("starve2", 1'b0, 1'b0);
      step();
    end
    both_req(5'd13, 32'h610);
    reset = 1'b1;
    ex("rst_force_waddr", K_WADDR, 32'd0);
    hs("rst_force", 1'b0, 1'b0);
    ex("rst_force_err", K_ERR, 32'd1);
    step();
    reset = 1'b0;
    idle_in(); pipe_wen = 1'b1; pipe_waddr = 5'd0; pipe_pc = 32'h620;
    mdu_valid = 1'b1; mdu_waddr = 5'd7; mdu_wdata = 32'h77; mdu_pc = 32'h700; rs_addr = 5'd10;
    grf("post_rst", 32'd7, 32'h77, 32'h700);
    hs("post_rst", 1'b0, 1'b1);
    ex("post_rst_err", K_ERR, 32'd0);
    ex("post_rst_rsb", K_RSB, 32'd0);
    step();
    idle_in();
    step();

    // Bounded drain of any expectations not yet compared.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
      @(negedge clk);
    end
    if (exp_q.size() > 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    #2;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
